// File: rtl/lieat_exu_com_csrunit_pkg.sv
// ---------------------------------------------------------------------------
// lieat_exu_com_csrunit_pkg
// Shared definitions for the commit-stage CSR unit:
//   - CSR_IDX_W            : CSR address width used by the constants below
//   - OP_* bit positions   : layout of the one-hot op vector {mret, ecall, csrrc, csrrs, csrrw}
//   - CSR_MEPC/MCAUSE/MTVEC: machine trap CSR addresses touched by trap entry / mret
//   - csr_state_e          : FSM state encoding of the CSR unit
//   - op_is_onehot()       : legality test applied to the op vector at accept
// ---------------------------------------------------------------------------
package lieat_exu_com_csrunit_pkg;

    localparam int CSR_IDX_W = 12;
    localparam int OP_W      = 5;

    localparam int OP_RW    = 0;
    localparam int OP_RS    = 1;
    localparam int OP_RC    = 2;
    localparam int OP_ECALL = 3;
    localparam int OP_MRET  = 4;

    localparam logic [CSR_IDX_W-1:0] CSR_MEPC   = 12'h341;
    localparam logic [CSR_IDX_W-1:0] CSR_MCAUSE = 12'h342;
    localparam logic [CSR_IDX_W-1:0] CSR_MTVEC  = 12'h305;

    // mcause for an illegal-instruction trap
    localparam int ILLEGAL_CAUSE = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_EPC   = 3'd3,
        ST_CAUSE = 3'd4,
        ST_VEC   = 3'd5,
        ST_RESP  = 3'd6
    } csr_state_e;

    function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - 5'd1)) == '0);
    endfunction

endpackage

// File: rtl/lieat_exu_csr_rmw.sv
// ---------------------------------------------------------------------------
// lieat_exu_csr_rmw
// Combinational read-modify-write new-value function for Zicsr ops.
// Ports:
//   op_rw_i, op_rs_i, op_rc_i : one-hot op select (csrrw / csrrs / csrrc)
//   old_i                     : CSR value captured in the read cycle
//   operand_i                 : rs1 value or zero-extended zimm
//   new_o                     : value to write back into the CSR
// ---------------------------------------------------------------------------
module lieat_exu_csr_rmw #(
    parameter int XLEN = 32
) (
    input  logic            op_rw_i,
    input  logic            op_rs_i,
    input  logic            op_rc_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] new_o
);

    always_comb begin
        new_o = '0;
        if (op_rw_i) begin
            new_o = operand_i;
        end else if (op_rs_i) begin
            new_o = old_i | operand_i;
        end else if (op_rc_i) begin
            new_o = old_i & ~operand_i;
        end
    end

endmodule

// File: rtl/lieat_exu_com_csrunit.sv
// ---------------------------------------------------------------------------
// lieat_exu_com_csrunit
// Multi-cycle CSR execution unit for the commit stage. Executes csrrw/csrrs/
// csrrc through a single CSR port (read cycle, then write cycle), sequences
// ecall trap entry (mepc, mcause, mtvec fetch) through that same port, and
// handles mret by reading mepc. Produces rd writeback data and a PC redirect.
//
// Optional build macro: LIEAT_CSR_ILLEGAL_EN
//   defined   : write-intent access to a read-only CSR (idx[11:10]==2'b11)
//               traps with mcause=2 and o_illegal=1 instead of writing.
//   undefined : o_illegal is tied 0 and such writes are issued normally.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_valid / i_ready   : request handshake (i_ready high only in IDLE)
//   i_pc, i_src1        : instruction PC, rs1 value
//   i_op                : one-hot {mret, ecall, csrrc, csrrs, csrrw}
//   i_rs1imm, i_zimm    : use zero-extended zimm instead of rs1
//   i_rs1_x0, i_rd_x0   : rs1/zimm is zero, rd is x0
//   i_csridx            : target CSR
//   o_valid / o_ready   : result handshake
//   o_wbck_data/_en     : old CSR value for rd, rd write enable
//   o_redirect/_pc      : PC redirect request and target
//   o_illegal           : illegal CSR access flag
//   csr_ena/write/idx/wdata, csr_rdata : single CSR register-file port
// ---------------------------------------------------------------------------
module lieat_exu_com_csrunit
    import lieat_exu_com_csrunit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CSR_IDX     = 12,
    parameter int ECALL_CAUSE = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_src1,
    input  logic [4:0]         i_op,
    input  logic               i_rs1imm,
    input  logic [4:0]         i_zimm,
    input  logic               i_rs1_x0,
    input  logic               i_rd_x0,
    input  logic [CSR_IDX-1:0] i_csridx,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [XLEN-1:0]    o_wbck_data,
    output logic               o_wbck_en,
    output logic               o_redirect,
    output logic [XLEN-1:0]    o_redirect_pc,
    output logic               o_illegal,
    output logic               csr_ena,
    output logic               csr_write,
    output logic [CSR_IDX-1:0] csr_idx,
    output logic [XLEN-1:0]    csr_wdata,
    input  logic [XLEN-1:0]    csr_rdata
);

    csr_state_e         state_q;
    logic [4:0]         op_q;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    src1_q;
    logic               rs1imm_q;
    logic [4:0]         zimm_q;
    logic               rs1_x0_q;
    logic               rd_x0_q;
    logic [CSR_IDX-1:0] idx_q;
    logic [XLEN-1:0]    old_q;
    logic [XLEN-1:0]    rpc_q;
    logic               illegal_q;

    logic [XLEN-1:0]    operand_d;
    logic [XLEN-1:0]    new_d;
    logic               is_csr_op;
    logic               skip_wr;
    logic               rd_strobe_off;
    logic               write_intent;

    assign operand_d     = rs1imm_q ? {{(XLEN-5){1'b0}}, zimm_q} : src1_q;
    assign is_csr_op     = op_q[OP_RW] | op_q[OP_RS] | op_q[OP_RC];
    // csrrs/csrrc with a zero source never modify the CSR
    assign skip_wr       = (op_q[OP_RS] | op_q[OP_RC]) & rs1_x0_q;
    // csrrw to x0 must not cause read side effects
    assign rd_strobe_off = op_q[OP_RW] & rd_x0_q;
    assign write_intent  = op_q[OP_RW] | ((op_q[OP_RS] | op_q[OP_RC]) & ~rs1_x0_q);

    lieat_exu_csr_rmw #(.XLEN(XLEN)) u_rmw (
        .op_rw_i   (op_q[OP_RW]),
        .op_rs_i   (op_q[OP_RS]),
        .op_rc_i   (op_q[OP_RC]),
        .old_i     (old_q),
        .operand_i (operand_d),
        .new_o     (new_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            pc_q      <= '0;
            src1_q    <= '0;
            rs1imm_q  <= 1'b0;
            zimm_q    <= '0;
            rs1_x0_q  <= 1'b0;
            rd_x0_q   <= 1'b0;
            idx_q     <= '0;
            old_q     <= '0;
            rpc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        pc_q      <= i_pc;
                        src1_q    <= i_src1;
                        rs1imm_q  <= i_rs1imm;
                        zimm_q    <= i_zimm;
                        rs1_x0_q  <= i_rs1_x0;
                        rd_x0_q   <= i_rd_x0;
                        idx_q     <= i_csridx;
                        old_q     <= '0;
                        rpc_q     <= '0;
                        illegal_q <= 1'b0;
                        if (!op_is_onehot(i_op)) begin
                            // malformed op completes as a nop
                            op_q    <= '0;
                            state_q <= ST_RESP;
                        end else begin
                            op_q <= i_op;
                            if (i_op[OP_ECALL])     state_q <= ST_EPC;
                            else if (i_op[OP_MRET]) state_q <= ST_VEC;
                            else                    state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    old_q <= rd_strobe_off ? '0 : csr_rdata;
`ifdef LIEAT_CSR_ILLEGAL_EN
                    if (write_intent && (idx_q[CSR_IDX-1 -: 2] == 2'b11)) begin
                        illegal_q <= 1'b1;
                        state_q   <= ST_EPC;
                    end else
`endif
                    if (skip_wr) state_q <= ST_RESP;
                    else         state_q <= ST_WR;
                end
                ST_WR:    state_q <= ST_RESP;
                ST_EPC:   state_q <= ST_CAUSE;
                ST_CAUSE: state_q <= ST_VEC;
                ST_VEC: begin
                    // mret returns to mepc as-is; trap entry uses the direct-mode mtvec base
                    rpc_q   <= op_q[OP_MRET] ? csr_rdata : {csr_rdata[XLEN-1:2], 2'b00};
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (o_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Single CSR port: address/data muxed by the current sequencing state
    always_comb begin
        csr_ena   = 1'b0;
        csr_write = 1'b0;
        csr_idx   = '0;
        csr_wdata = '0;
        case (state_q)
            ST_RD: begin
                csr_ena = ~rd_strobe_off;
                csr_idx = idx_q;
            end
            ST_WR: begin
                csr_ena   = 1'b1;
                csr_write = 1'b1;
                csr_idx   = idx_q;
                csr_wdata = new_d;
            end
            ST_EPC: begin
                csr_ena   = 1'b1;
                csr_write = 1'b1;
                csr_idx   = CSR_IDX'(CSR_MEPC);
                csr_wdata = pc_q;
            end
            ST_CAUSE: begin
                csr_ena   = 1'b1;
                csr_write = 1'b1;
                csr_idx   = CSR_IDX'(CSR_MCAUSE);
                csr_wdata = illegal_q ? XLEN'(ILLEGAL_CAUSE) : XLEN'(ECALL_CAUSE);
            end
            ST_VEC: begin
                csr_ena = 1'b1;
                csr_idx = op_q[OP_MRET] ? CSR_IDX'(CSR_MEPC) : CSR_IDX'(CSR_MTVEC);
            end
            default: ;
        endcase
    end

    assign i_ready       = (state_q == ST_IDLE);
    assign o_valid       = (state_q == ST_RESP);
    assign o_wbck_data   = old_q;
    assign o_redirect_pc = rpc_q;
    assign o_wbck_en     = o_valid & is_csr_op & ~rd_x0_q & ~illegal_q;
    assign o_redirect    = o_valid & (op_q[OP_ECALL] | op_q[OP_MRET] | illegal_q);
`ifdef LIEAT_CSR_ILLEGAL_EN
    assign o_illegal     = o_valid & illegal_q;
`else
    assign o_illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_lieat_exu_com_csrunit.sv
module tb_lieat_exu_com_csrunit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_pc;
    logic [31:0] i_src1;
    logic [4:0]  i_op;
    logic        i_rs1imm;
    logic [4:0]  i_zimm;
    logic        i_rs1_x0;
    logic        i_rd_x0;
    logic [11:0] i_csridx;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_wbck_data;
    logic        o_wbck_en;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_illegal;
    logic        csr_ena;
    logic        csr_write;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    always #5 clk = ~clk;

    lieat_exu_com_csrunit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_pc          (i_pc),
        .i_src1        (i_src1),
        .i_op          (i_op),
        .i_rs1imm      (i_rs1imm),
        .i_zimm        (i_zimm),
        .i_rs1_x0      (i_rs1_x0),
        .i_rd_x0       (i_rd_x0),
        .i_csridx      (i_csridx),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_wbck_data   (o_wbck_data),
        .o_wbck_en     (o_wbck_en),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc),
        .o_illegal     (o_illegal),
        .csr_ena       (csr_ena),
        .csr_write     (csr_write),
        .csr_idx       (csr_idx),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata)
    );

    // CSR register file model with access logging
    logic [31:0] mem [4096];
    logic [11:0] wlog_idx [64];
    logic [31:0] wlog_dat [64];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          hs_cnt = 0;
    logic        pre_en = 1'b0;
    logic [11:0] pre_idx = '0;
    logic [31:0] pre_val = '0;

    assign csr_rdata = mem[csr_idx];

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        if (csr_ena && csr_write) begin
            mem[csr_idx]           <= csr_wdata;
            wlog_idx[wr_cnt % 64]  <= csr_idx;
            wlog_dat[wr_cnt % 64]  <= csr_wdata;
            wr_cnt                 <= wr_cnt + 1;
        end
        if (csr_ena && !csr_write) rd_cnt <= rd_cnt + 1;
        if (o_valid && o_ready)    hs_cnt <= hs_cnt + 1;
    end

    int nchk  = 0;
    int npass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    // Present one request, then count cycles from accept until o_valid (bounded)
    task automatic issue(input logic [4:0] op, input logic [31:0] src1, input logic rs1imm,
                         input logic [4:0] zimm, input logic rs1_x0, input logic rd_x0,
                         input logic [11:0] idx, input logic [31:0] pc, output int lat);
        i_op     = op;
        i_src1   = src1;
        i_rs1imm = rs1imm;
        i_zimm   = zimm;
        i_rs1_x0 = rs1_x0;
        i_rd_x0  = rd_x0;
        i_csridx = idx;
        i_pc     = pc;
        i_valid  = 1'b1;
        @(posedge clk); #1;
        i_valid  = 1'b0;
        i_op     = 5'b11111;
        i_src1   = 32'hFFFF_FFFF;
        i_zimm   = 5'h1F;
        i_csridx = 12'hFFF;
        i_pc     = 32'hFFFF_FFFF;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_resp(input string tag);
        o_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_iready_after"}, 32'(i_ready), 32'd1);
        check({tag, "_ovalid_after"}, 32'(o_valid), 32'd0);
    endtask

    int lat;
    int w0;
    int r0;
    int h0;
    int bad;

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_pc     = '0;
        i_src1   = '0;
        i_op     = '0;
        i_rs1imm = 1'b0;
        i_zimm   = '0;
        i_rs1_x0 = 1'b0;
        i_rd_x0  = 1'b0;
        i_csridx = '0;
        o_ready  = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_iready",   32'(i_ready), 32'd1);
        check("rst_ovalid",   32'(o_valid), 32'd0);
        check("rst_csr_ena",  32'(csr_ena), 32'd0);
        check("rst_wbck_dat", o_wbck_data, 32'd0);
        check("rst_rpc",      o_redirect_pc, 32'd0);
        check("rst_redirect", 32'(o_redirect), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        preload(12'h300, 32'h0000_0008);
        preload(12'h301, 32'h0000_00FF);
        preload(12'h340, 32'h0000_1234);
        preload(12'h305, 32'h8000_0101);
        preload(12'hC00, 32'h0000_0077);
        o_ready = 1'b1;

        // csrrs x5, mstatus, src1=0x80
        w0 = wr_cnt; r0 = rd_cnt;
        issue(5'b00010, 32'h80, 1'b0, 5'd0, 1'b0, 1'b0, 12'h300, 32'h0, lat);
        check("rs_lat",     32'(lat), 32'd3);
        check("rs_wbck",    o_wbck_data, 32'h8);
        check("rs_wbck_en", 32'(o_wbck_en), 32'd1);
        check("rs_redir",   32'(o_redirect), 32'd0);
        check("rs_nwr",     32'(wr_cnt - w0), 32'd1);
        check("rs_wr_idx",  32'(wlog_idx[w0 % 64]), 32'h300);
        check("rs_wr_dat",  wlog_dat[w0 % 64], 32'h88);
        check("rs_nrd",     32'(rd_cnt - r0), 32'd1);
        finish_resp("rs");

        // csrrc with rs1_x0: read only
        w0 = wr_cnt; r0 = rd_cnt;
        issue(5'b00100, 32'hFFFF, 1'b0, 5'd0, 1'b1, 1'b0, 12'h301, 32'h0, lat);
        check("rcx0_lat",     32'(lat), 32'd2);
        check("rcx0_wbck",    o_wbck_data, 32'hFF);
        check("rcx0_wbck_en", 32'(o_wbck_en), 32'd1);
        check("rcx0_nwr",     32'(wr_cnt - w0), 32'd0);
        check("rcx0_nrd",     32'(rd_cnt - r0), 32'd1);
        finish_resp("rcx0");

        // csrrwi x0, 0x340, 5: no read strobe
        w0 = wr_cnt; r0 = rd_cnt;
        issue(5'b00001, 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b0, 1'b1, 12'h340, 32'h0, lat);
        check("rwi_lat",     32'(lat), 32'd3);
        check("rwi_nrd",     32'(rd_cnt - r0), 32'd0);
        check("rwi_nwr",     32'(wr_cnt - w0), 32'd1);
        check("rwi_wr_idx",  32'(wlog_idx[w0 % 64]), 32'h340);
        check("rwi_wr_dat",  wlog_dat[w0 % 64], 32'h5);
        check("rwi_wbck_en", 32'(o_wbck_en), 32'd0);
        check("rwi_wbck",    o_wbck_data, 32'h0);
        finish_resp("rwi");

        // csrrc 0x300 (now 0x88) with src1=0x08
        w0 = wr_cnt;
        issue(5'b00100, 32'h08, 1'b0, 5'd0, 1'b0, 1'b0, 12'h300, 32'h0, lat);
        check("rc_lat",    32'(lat), 32'd3);
        check("rc_wbck",   o_wbck_data, 32'h88);
        check("rc_wr_dat", wlog_dat[w0 % 64], 32'h80);
        finish_resp("rc");

        // ecall
        w0 = wr_cnt;
        issue(5'b01000, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 12'h0, 32'h8000_0010, lat);
        check("ecall_lat",     32'(lat), 32'd4);
        check("ecall_nwr",     32'(wr_cnt - w0), 32'd2);
        check("ecall_w0_idx",  32'(wlog_idx[w0 % 64]), 32'h341);
        check("ecall_w0_dat",  wlog_dat[w0 % 64], 32'h8000_0010);
        check("ecall_w1_idx",  32'(wlog_idx[(w0 + 1) % 64]), 32'h342);
        check("ecall_w1_dat",  wlog_dat[(w0 + 1) % 64], 32'd11);
        check("ecall_redir",   32'(o_redirect), 32'd1);
        check("ecall_rpc",     o_redirect_pc, 32'h8000_0100);
        check("ecall_wbck_en", 32'(o_wbck_en), 32'd0);
        check("ecall_illegal", 32'(o_illegal), 32'd0);
        finish_resp("ecall");

        // mret with back-pressure
        preload(12'h341, 32'h8000_0020);
        o_ready = 1'b0;
        h0 = hs_cnt;
        issue(5'b10000, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 12'h0, 32'h0, lat);
        check("mret_lat",     32'(lat), 32'd2);
        check("mret_rpc",     o_redirect_pc, 32'h8000_0020);
        check("mret_wbck_en", 32'(o_wbck_en), 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!o_valid || i_ready || csr_ena || !o_redirect ||
                o_redirect_pc !== 32'h8000_0020) bad++;
            @(posedge clk); #1;
        end
        check("mret_hold_bad", 32'(bad), 32'd0);
        finish_resp("mret");
        check("mret_hs", 32'(hs_cnt - h0), 32'd1);

        // csrrw 0x305 (0x80000101) <- 0x11
        w0 = wr_cnt;
        issue(5'b00001, 32'h11, 1'b0, 5'd0, 1'b0, 1'b0, 12'h305, 32'h0, lat);
        check("rw_wbck",    o_wbck_data, 32'h8000_0101);
        check("rw_wbck_en", 32'(o_wbck_en), 32'd1);
        check("rw_wr_dat",  wlog_dat[w0 % 64], 32'h11);
        finish_resp("rw");

        // multi-hot op behaves as nop
        w0 = wr_cnt; r0 = rd_cnt;
        issue(5'b00011, 32'h1, 1'b0, 5'd0, 1'b0, 1'b0, 12'h300, 32'h0, lat);
        check("nop_lat",     32'(lat), 32'd1);
        check("nop_wbck_en", 32'(o_wbck_en), 32'd0);
        check("nop_redir",   32'(o_redirect), 32'd0);
        check("nop_access",  32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
        finish_resp("nop");

        // csrrw to read-only CSR 0xC00
        w0 = wr_cnt;
        issue(5'b00001, 32'h55, 1'b0, 5'd0, 1'b0, 1'b0, 12'hC00, 32'h1000, lat);
`ifdef LIEAT_CSR_ILLEGAL_EN
        check("ill_lat",     32'(lat), 32'd5);
        check("ill_nwr",     32'(wr_cnt - w0), 32'd2);
        check("ill_w0_idx",  32'(wlog_idx[w0 % 64]), 32'h341);
        check("ill_w0_dat",  wlog_dat[w0 % 64], 32'h1000);
        check("ill_w1_idx",  32'(wlog_idx[(w0 + 1) % 64]), 32'h342);
        check("ill_w1_dat",  wlog_dat[(w0 + 1) % 64], 32'd2);
        check("ill_flag",    32'(o_illegal), 32'd1);
        check("ill_wbck_en", 32'(o_wbck_en), 32'd0);
        check("ill_redir",   32'(o_redirect), 32'd1);
        check("ill_rpc",     o_redirect_pc, 32'h10);
`else
        check("ro_lat",     32'(lat), 32'd3);
        check("ro_nwr",     32'(wr_cnt - w0), 32'd1);
        check("ro_wr_idx",  32'(wlog_idx[w0 % 64]), 32'hC00);
        check("ro_wr_dat",  wlog_dat[w0 % 64], 32'h55);
        check("ro_flag",    32'(o_illegal), 32'd0);
        check("ro_wbck",    o_wbck_data, 32'h77);
        check("ro_wbck_en", 32'(o_wbck_en), 32'd1);
`endif
        finish_resp("ro");

        // asynchronous reset during trap entry (mepc write cycle)
        i_op     = 5'b01000;
        i_pc     = 32'h0000_2000;
        i_valid  = 1'b1;
        @(posedge clk); #1;
        i_valid  = 1'b0;
        check("rstmid_epc_wr", 32'(csr_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_iready", 32'(i_ready), 32'd1);
        check("rstmid_ena",    32'(csr_ena), 32'd0);
        check("rstmid_ovalid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstmid_idle", 32'(i_ready), 32'd1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
